// File: rtl/pwm_move_seq.sv
// Servo move sequencer. Commands are queued in a small FIFO. Each move writes the
// channel duty register over the cs/addr/wr/rd bus, reads the value back and
// compares it, then holds for the requested number of cycles.
//
//  state   | meaning
//  --------+------------------------------------------------
//  S_IDLE  | waiting for a queued command; pops head when present
//  S_CHK   | validate channel number
//  S_WRITE | cs/wr strobe with duty on d_in
//  S_READ  | cs/rd strobe for readback
//  S_CMP   | compare d_out to written duty
//  S_HOLD  | count down hold time before next move
module pwm_move_seq #(
    parameter int         NCH        = 2,
    parameter logic [7:0] DUTY_BASE  = 8'h04,
    parameter int         FIFO_DEPTH = 4,
    parameter int         HOLD_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_ch,
    input  logic [31:0]       cmd_duty,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic              cs,
    output logic [7:0]        addr,
    output logic              wr,
    output logic              rd,
    output logic [31:0]       d_in,
    input  logic [31:0]       d_out,
    output logic              busy,
    output logic              move_done,
    output logic              err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 3 + 32 + HOLD_W;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [3:0]  NCH_C   = 4'(NCH);

    typedef enum logic [2:0] {S_IDLE, S_CHK, S_WRITE, S_READ, S_CMP, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [EW-1:0]     mem_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic [2:0]        ch_q, ch_d;
    logic [31:0]       duty_q, duty_d;
    logic [HOLD_W-1:0] hold_q, hold_d, cnt_q, cnt_d;
    logic              cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
    logic [7:0]        addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic              done_q, done_d, err_q, err_d;
    logic              push, pop, full;
    logic [EW-1:0]     head;
    logic [7:0]        bus_addr;

    assign full      = (count_q == DEPTH_C);
    assign cmd_ready = ~full;
    assign push      = cmd_valid & ~full;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign head      = mem_q[rd_ptr_q];
    assign bus_addr  = DUTY_BASE + {5'd0, ch_q};

    // FIFO storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {cmd_ch, cmd_duty, cmd_hold};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Move FSM next state; bus outputs are computed for the state being entered
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    ch_d    = head[EW-1 -: 3];
                    duty_d  = head[HOLD_W +: 32];
                    hold_d  = head[HOLD_W-1:0];
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if ({1'b0, ch_q} >= NCH_C) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = bus_addr;
                    din_d   = duty_q;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                cs_d    = 1'b1;
                rd_d    = 1'b1;
                addr_d  = bus_addr;
                state_d = S_READ;
            end
            S_READ: state_d = S_CMP;
            S_CMP: begin
                if (d_out != duty_q) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (hold_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = hold_q;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q != '0) cnt_d = cnt_q - HOLD_W'(1);
                if (cnt_q <= HOLD_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, FIFO and registered bus outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ch_q     <= '0;
            duty_q   <= '0;
            hold_q   <= '0;
            cnt_q    <= '0;
            cs_q     <= 1'b0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ch_q     <= ch_d;
            duty_q   <= duty_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            cs_q     <= cs_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cs        = cs_q;
    assign wr        = wr_q;
    assign rd        = rd_q;
    assign addr      = addr_q;
    assign d_in      = din_q;
    assign move_done = done_q;
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_pwm_move_seq.sv
// Directed bench for pwm_move_seq with a simple register-slave model.
module tb_pwm_move_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_ch;
    logic [31:0] cmd_duty;
    logic [15:0] cmd_hold;
    logic        cs, wr, rd, busy, move_done, err;
    logic [7:0]  addr;
    logic [31:0] d_in;
    logic [31:0] d_out;

    pwm_move_seq dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_duty(cmd_duty), .cmd_hold(cmd_hold),
        .cs(cs), .addr(addr), .wr(wr), .rd(rd), .d_in(d_in), .d_out(d_out),
        .busy(busy), .move_done(move_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; logic [7:0] a; logic [31:0] d;} wr_ev_t;
    typedef struct {int cyc; logic e;} done_ev_t;

    int       cyc = 0;
    int       total = 0;
    int       passed = 0;
    int       rd_cnt = 0;
    int       corrupt_at = -1;
    int       cs_cnt = 0;
    int       busy_cnt = 0;
    wr_ev_t   wr_log[$];
    int       rd_log[$];
    done_ev_t done_log[$];
    logic [31:0] regs [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Register slave: read data valid one cycle after rd; optional one-shot corruption
    always @(posedge clk) begin
        if (cs && wr) regs[addr] <= d_in;
        if (cs && rd) begin
            d_out  <= (rd_cnt == corrupt_at) ? regs[addr] - 32'd1 : regs[addr];
            rd_cnt <= rd_cnt + 1;
        end
    end

    // Bus monitor and protocol checks
    always @(negedge clk) begin
        wr_ev_t   w;
        done_ev_t dn;
        if (cs) cs_cnt++;
        if (busy) busy_cnt++;
        if (wr) begin
            w.cyc = cyc; w.a = addr; w.d = d_in;
            wr_log.push_back(w);
        end
        if (rd) rd_log.push_back(cyc);
        if (move_done) begin
            dn.cyc = cyc; dn.e = err;
            done_log.push_back(dn);
        end
        chk("wr_rd_exclusive", {31'd0, wr & rd}, 32'd0);
        chk("cs_matches_strobe", {31'd0, cs}, {31'd0, wr | rd});
    end

    task automatic clr_logs();
        @(posedge clk);
        #1;
        wr_log.delete(); rd_log.delete(); done_log.delete();
        cs_cnt = 0; busy_cnt = 0;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the following negedge after the transfer
    task automatic push(input logic [2:0] ch, input logic [31:0] duty,
                        input logic [15:0] hold, output int acc);
        int n = 0;
        cmd_valid = 1'b1; cmd_ch = ch; cmd_duty = duty; cmd_hold = hold;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("push_timeout", {31'd0, cmd_ready}, 32'd1);
        acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (done_log.size() < n && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("done_timeout", {31'd0, done_log.size() >= n}, 32'd1);
    endtask

    initial begin
        int c, c2, cf;
        rst = 1'b1; cmd_valid = 1'b0; cmd_ch = '0; cmd_duty = '0; cmd_hold = '0;
        for (int i = 0; i < 256; i++) regs[i] = '0;
        d_out = '0;

        // Power-on reset values
        @(negedge clk);
        chk("rst_cs", {31'd0, cs}, 0);
        chk("rst_wr", {31'd0, wr}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_ready", {31'd0, cmd_ready}, 1);
        chk("rst_addr", {24'd0, addr}, 0);
        rst = 1'b0;
        clr_logs();

        // Single move, hold=0
        push(3'd1, 32'd1500, 16'd0, c);
        wait_done(1);
        chk("t2_wr_cyc", wr_log[0].cyc, c + 3);
        chk("t2_wr_addr", {24'd0, wr_log[0].a}, 32'h05);
        chk("t2_wr_data", wr_log[0].d, 32'd1500);
        chk("t2_rd_cyc", rd_log[0], c + 4);
        chk("t2_done_cyc", done_log[0].cyc, c + 6);
        chk("t2_err", {31'd0, done_log[0].e}, 0);
        chk("t2_busy_cycles", busy_cnt, 4);
        clr_logs();

        // Hold of 10 cycles
        push(3'd0, 32'd1000, 16'd10, c);
        wait_done(1);
        chk("t3_wr_addr", {24'd0, wr_log[0].a}, 32'h04);
        chk("t3_wr_data", wr_log[0].d, 32'd1000);
        chk("t3_done_cyc", done_log[0].cyc, c + 16);
        chk("t3_busy_cycles", busy_cnt, 14);
        clr_logs();

        // Readback mismatch, next move still runs
        corrupt_at = rd_cnt;
        push(3'd0, 32'd1000, 16'd0, c);
        push(3'd1, 32'd2000, 16'd0, c2);
        wait_done(2);
        chk("t5_done0_cyc", done_log[0].cyc, c + 6);
        chk("t5_done0_err", {31'd0, done_log[0].e}, 1);
        chk("t5_wr1_cyc", wr_log[1].cyc, c + 8);
        chk("t5_wr1_addr", {24'd0, wr_log[1].a}, 32'h05);
        chk("t5_wr1_data", wr_log[1].d, 32'd2000);
        chk("t5_done1_cyc", done_log[1].cyc, c + 11);
        chk("t5_err_sticky", {31'd0, done_log[1].e}, 1);
        corrupt_at = -1;
        clr_logs();

        // Reset in the middle of a hold, with a command still queued
        push(3'd1, 32'd300, 16'd50, c);
        push(3'd0, 32'd400, 16'd0, c2);
        repeat (10) @(negedge clk);
        chk("t1_pre_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        #1;
        chk("t1_busy", {31'd0, busy}, 0);
        chk("t1_err", {31'd0, err}, 0);
        chk("t1_done", {31'd0, move_done}, 0);
        chk("t1_cs", {31'd0, cs | wr | rd}, 0);
        chk("t1_addr", {24'd0, addr}, 0);
        chk("t1_din", d_in, 0);
        chk("t1_ready", {31'd0, cmd_ready}, 1);
        @(negedge clk);
        rst = 1'b0;
        clr_logs();
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        chk("t1_no_cs_after", cs_cnt, 0);
        chk("t1_fifo_empty", busy_cnt, 0);
        @(negedge clk);
        clr_logs();

        // Illegal channel: no bus access, err set
        push(3'd3, 32'd77, 16'd5, c);
        wait_done(1);
        chk("t6_done_cyc", done_log[0].cyc, c + 3);
        chk("t6_err", {31'd0, done_log[0].e}, 1);
        chk("t6_no_cs", cs_cnt, 0);
        chk("t6_busy_cycles", busy_cnt, 1);
        clr_logs();

        // FIFO fill while a long hold is in progress
        push(3'd0, 32'd100, 16'd20, c);
        push(3'd1, 32'd201, 16'd0, c2);
        push(3'd0, 32'd202, 16'd0, c2);
        push(3'd1, 32'd203, 16'd0, c2);
        push(3'd0, 32'd204, 16'd0, c2);
        chk("t4_ready_low", {31'd0, cmd_ready}, 0);
        push(3'd1, 32'd205, 16'd0, cf);
        chk("t4_stall_accept", cf - c, 27);
        wait_done(6);
        chk("t4_wr_count", wr_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < wr_log.size()) begin
                chk("t4_wr_addr", {24'd0, wr_log[i].a}, (i % 2 == 0) ? 32'h04 : 32'h05);
                chk("t4_wr_data", wr_log[i].d, (i == 0) ? 32'd100 : 32'd200 + 32'(i));
            end
        end
        chk("t4_last_done", done_log[5].cyc, c + 51);
        chk("t4_err_sticky", {31'd0, err}, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
